// File: rtl/keypad_if.sv
// Keypad entry bundle: raw key lines and entry controls in, BCD digit and M:SS entry out.
interface keypad_if;
  logic [9:0] keypad;
  logic       clearn;
  logic       lock;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic [3:0] minutes_bcd;
  logic [3:0] sec_tens_bcd;
  logic [3:0] sec_ones_bcd;
  logic       entry_nonzero;

  modport master (
    output keypad, clearn, lock,
    input  digit_out, digit_valid, minutes_bcd, sec_tens_bcd, sec_ones_bcd, entry_nonzero
  );

  modport slave (
    input  keypad, clearn, lock,
    output digit_out, digit_valid, minutes_bcd, sec_tens_bcd, sec_ones_bcd, entry_nonzero
  );
endinterface

// File: rtl/keypad_entry.sv
// Debounces a 10-line decimal keypad, encodes accepted presses to BCD and shifts them into M:SS.
// Optional macro KEYPAD_SYNC_EN inserts a 2-flop synchroniser ahead of the debounce FSM.
module keypad_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input logic     clk,
  input logic     reset,
  keypad_if.slave kif
);

  typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} state_e;

  localparam logic [CNT_W-1:0] CntDone = CNT_W'(DEBOUNCE_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [9:0]       code_q, code_d;
  logic [9:0]       key_s;
  logic             key_zero, key_valid, accept;
  logic [3:0]       digit_out_q, min_q, tens_q, ones_q;
  logic             digit_valid_q;

`ifdef KEYPAD_SYNC_EN
  logic [9:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= kif.keypad;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = sync2_q;
`else
  assign key_s = kif.keypad;
`endif

  function automatic logic [3:0] encode(logic [9:0] code);
    logic [3:0] d;
    d = '0;
    for (int k = 0; k < 10; k++) begin
      if (code[k]) d = 4'(k);
    end
    return d;
  endfunction

  assign key_zero  = (key_s == '0);
  // Exactly one line high: non-zero and clearing the lowest set bit leaves nothing.
  assign key_valid = !key_zero && ((key_s & (key_s - 10'd1)) == '0);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    accept  = 1'b0;
    if (kif.lock) begin
      state_d = StReleaseWait;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (key_valid) begin
            state_d = StPressWait;
            code_d  = key_s;
            cnt_d   = CNT_W'(1);
          end else if (!key_zero) begin
            state_d = StReleaseWait;
            cnt_d   = '0;
          end
        end
        StPressWait: begin
          if (key_s == code_q) begin
            if (cnt_inc == CntDone) begin
              state_d = StHeld;
              cnt_d   = '0;
              accept  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (!key_zero && !key_valid) begin
            state_d = StReleaseWait;
            cnt_d   = '0;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StHeld: begin
          if (key_zero) begin
            state_d = StReleaseWait;
            cnt_d   = CNT_W'(1);
          end
        end
        StReleaseWait: begin
          if (!key_zero) begin
            cnt_d = '0;
          end else if (cnt_inc == CntDone) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  // Clear beats a simultaneous accept: the pulse is swallowed but the FSM still reaches HELD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_out_q   <= '0;
      digit_valid_q <= 1'b0;
      min_q         <= '0;
      tens_q        <= '0;
      ones_q        <= '0;
    end else begin
      digit_valid_q <= accept && kif.clearn;
      if (accept) digit_out_q <= encode(code_q);
      if (!kif.clearn) begin
        min_q  <= '0;
        tens_q <= '0;
        ones_q <= '0;
      end else if (accept) begin
        min_q  <= tens_q;
        tens_q <= ones_q;
        ones_q <= encode(code_q);
      end
    end
  end

  assign kif.digit_out     = digit_out_q;
  assign kif.digit_valid   = digit_valid_q;
  assign kif.minutes_bcd   = min_q;
  assign kif.sec_tens_bcd  = tens_q;
  assign kif.sec_ones_bcd  = ones_q;
  assign kif.entry_nonzero = |{min_q, tens_q, ones_q};

endmodule
